serial_subtractor: RTL and testbench

//   Multi-cycle, parametrised N-bit subtractor built from full-subtractor cells.

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/fs_bit_cell.sv | 15 +
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    function automatic int step_count(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    // Counter must hold 0..N inclusive.
    function automatic int cnt_width(input int width, input int bits_per_cycle);
        return $clog2(step_count(width, bits_per_cycle) + 1);
    endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
// Latency: combinational.
// Backpressure: none.
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle A - B - BIN, BITS_PER_CYCLE bits per clock, LSB first.
// Latency: WIDTH/BITS_PER_CYCLE + 1 edges from accepted start to done.
// Backpressure: start ignored while busy; accepted in IDLE or in the done cycle.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = step_count(WIDTH, BITS_PER_CYCLE);
    localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
            (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $error("serial_subtractor: illegal WIDTH/BITS_PER_CYCLE combination");
        end
    endgenerate

    sub_state_e             state_q;
    sub_state_e             state_d;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       a_sr;
    logic [WIDTH-1:0]       b_sr;
    logic [WIDTH-1:0]       res_sr;
    logic                   brw_q;
    logic                   a_msb_q;
    logic                   b_msb_q;
    logic                   accept;
    logic                   last_step;

    logic [BITS_PER_CYCLE-1:0]       d_vec;
    logic [BITS_PER_CYCLE:0]         brw_chain;
    logic [WIDTH+BITS_PER_CYCLE-1:0] res_cat;
    logic [WIDTH-1:0]                res_nxt;

    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign last_step = (state_q == RUN) && (cnt_q == LAST);

    assign brw_chain[0] = brw_q;

    generate
        for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
            fs_bit_cell u_cell (
                .a  (a_sr[i]),
                .b  (b_sr[i]),
                .bi (brw_chain[i]),
                .d  (d_vec[i]),
                .bo (brw_chain[i+1])
            );
        end
    endgenerate

    // New result bits enter at the MSB end; after N steps bit 0 lands at diff[0].
    assign res_cat = {d_vec, res_sr};
    assign res_nxt = res_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            brw_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            a_sr    <= a;
            b_sr    <= b;
            res_sr  <= '0;
            brw_q   <= bin;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == RUN) begin
            cnt_q  <= cnt_q + CW'(1);
            a_sr   <= a_sr >> BITS_PER_CYCLE;
            b_sr   <= b_sr >> BITS_PER_CYCLE;
            res_sr <= res_nxt;
            brw_q  <= brw_chain[BITS_PER_CYCLE];
            if (last_step) begin
                diff <= res_nxt;
                bout <= brw_chain[BITS_PER_CYCLE];
                ovf  <= (a_msb_q != b_msb_q) && (res_nxt[WIDTH-1] != a_msb_q);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table on 8x1, N=1 corner on 8x8,
// and random operands on 16x4 against an arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit, 1 bit/cycle
    logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    // 16-bit, 4 bits/cycle
    logic        start16 = 1'b0, bin16 = 1'b0, busy16, done16, bout16, ovf16;
    logic [15:0] a16 = '0, b16 = '0, diff16;
    // 8-bit, 8 bits/cycle (N=1)
    logic       start1 = 1'b0, bin1 = 1'b0, busy1, done1, bout1, ovf1;
    logic [7:0] a1 = '0, b1 = '0, diff1;

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8));

    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16));

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1));

    int checks = 0;
    int errors = 0;
    logic [7:0] prev8 = '0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        string      nm;
    } vec_t;

    typedef struct {
        longint d;
        bit     bo;
        bit     ov;
    } res_t;

    vec_t vecs[8];

    // Reference: plain integer arithmetic on unsigned and two's-complement views.
    function automatic res_t model(input int w, input longint ua, input longint ub, input int bi);
        res_t   r;
        longint m   = longint'(1) << w;
        longint h   = longint'(1) << (w - 1);
        longint sa  = (ua >= h) ? ua - m : ua;
        longint sb  = (ub >= h) ? ub - m : ub;
        longint sr  = sa - sb - longint'(bi);
        longint ur  = ua - ub - longint'(bi);
        r.d  = ((ur % m) + m) % m;
        r.bo = ua < ub + longint'(bi);
        r.ov = (sr < -h) || (sr > h - 1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op on the 8x1 instance; inj>0 pulses a spurious start with a=AA in that RUN cycle.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input logic [7:0] ed, input logic ebo, input logic eov,
                        input int inj, input string nm);
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        for (int c = 1; c <= 8; c++) begin
            chk({nm, "_busy"}, 32'(busy8), 32'd1);
            chk({nm, "_nodone"}, 32'(done8), 32'd0);
            chk({nm, "_hold"}, 32'(diff8), 32'(prev8));
            if (c == inj) begin
                start8 = 1'b1;
                a8 = 8'hAA;
            end
            tick();
            start8 = 1'b0;
        end
        chk({nm, "_done"}, 32'(done8), 32'd1);
        chk({nm, "_idlebusy"}, 32'(busy8), 32'd0);
        chk({nm, "_diff"}, 32'(diff8), 32'(ed));
        chk({nm, "_bout"}, 32'(bout8), 32'(ebo));
        chk({nm, "_ovf"}, 32'(ovf8), 32'(eov));
        prev8 = ed;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int     lat;
        res_t   r;

        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "t1"};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "t2a"};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "t2b"};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "t3a"};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "t3b"};
        vecs[5] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, "eq"};
        vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, "wrap"};
        vecs[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, "negov"};

        #12;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_diff16", 32'(diff16), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ov, 0, vecs[i].nm);
            tick();
            chk({vecs[i].nm, "_pulse"}, 32'(done8), 32'd0);
        end

        // Spurious start mid-run, then back-to-back start in the done cycle.
        run8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 4, "ignore");
        run8(8'h44, 8'h04, 1'b0, 8'h40, 1'b0, 1'b0, 0, "b2b");
        tick();
        chk("b2b_idle", 32'(busy8 | done8), 32'd0);

        // Reset in cycle 5 of a run.
        a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("abort_busy_pre", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_flags", 32'({bout8, ovf8}), 32'd0);
        tick();
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8 || busy8) lat++;
            tick();
        end
        chk("abort_nodone", 32'(lat), 32'd0);
        prev8 = '0;
        run8(8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0, 0, "after_rst");
        tick();

        // N=1: busy one cycle, done in cycle 2.
        for (int i = 0; i < 20; i++) begin
            a1 = 8'($urandom); b1 = 8'($urandom); bin1 = 1'($urandom);
            if (i == 0) begin a1 = 8'h00; b1 = 8'hFF; bin1 = 1'b1; end
            r = model(8, longint'(a1), longint'(b1), int'(bin1));
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("n1_busy", 32'({busy1, done1}), 32'b10);
            tick();
            chk("n1_done", 32'({busy1, done1}), 32'b01);
            chk("n1_res", 32'({ovf1, bout1, diff1}), 32'({r.ov, r.bo, 8'(r.d)}));
            tick();
        end

        // 16x4 random; start is re-asserted in the done cycle unless an idle gap is chosen.
        for (int i = 0; i < 2000; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
            r = model(16, longint'(a16), longint'(b16), int'(bin16));
            start16 = 1'b1;
            tick();
            start16 = 1'b0;
            a16 = 16'($urandom); b16 = 16'($urandom);
            lat = 1;
            while (!done16 && lat < 20) begin
                tick();
                lat++;
            end
            chk("r16_latency", 32'(lat), 32'd5);
            chk("r16_res", 32'({ovf16, bout16, diff16}), 32'({r.ov, r.bo, 16'(r.d)}));
            if ($urandom_range(3) == 0) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
